rvfpm_commit_queue: RTL

In-order issue/commit controller between the CORE-V-XIF issue and commit interfaces and the rvfpm execution pipeline. Buffers accepted offloaded instructions and releases each to the FPU only after the core has committed it. Instructions the core kills are silently discarded. Result: the FPU never starts a speculative instruction.

---
 rtl/rvfpm_commit_queue.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/rvfpm_commit_queue.sv
// rvfpm_commit_queue
// In-order issue/commit buffer between the CORE-V-XIF issue/commit interfaces
// and the rvfpm execution pipeline. An accepted instruction waits in the queue
// until the core commits it. Killed entries are dropped at the head without
// ever reaching the FPU, so the FPU never starts a speculative instruction.
//
// Optional feature macro: RVFPM_COMMIT_QUEUE_STATS_EN adds the disp_cnt and
// kill_cnt counters.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. disp_valid never depends on disp_ready, and once disp_valid is high,
// it and the presented head stay stable until disp_ready is sampled 1.
module rvfpm_commit_queue #(
    parameter int DEPTH      = 4,
    parameter int X_ID_WIDTH = 4
) (
    input  logic                    ck,
    input  logic                    rst,
    input  logic                    issue_valid,
    output logic                    issue_ready,
    input  logic                    issue_accept,
    input  logic [31:0]             issue_instr,
    input  logic [X_ID_WIDTH-1:0]   issue_id,
    input  logic                    commit_valid,
    input  logic [X_ID_WIDTH-1:0]   commit_id,
    input  logic                    commit_kill,
    output logic                    disp_valid,
    input  logic                    disp_ready,
    output logic [31:0]             disp_instr,
    output logic [X_ID_WIDTH-1:0]   disp_id,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    commit_err
`ifdef RVFPM_COMMIT_QUEUE_STATS_EN
    ,
    output logic [31:0]             disp_cnt,
    output logic [31:0]             kill_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0]      ent_valid;
    logic [DEPTH-1:0]      ent_committed;
    logic [DEPTH-1:0]      ent_killed;
    logic [31:0]           ent_instr [DEPTH];
    logic [X_ID_WIDTH-1:0] ent_id    [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;

    logic push;
    logic pop;
    logic kill_pop;
    logic disp_fire;

    logic          cm_hit;
    logic [PW-1:0] cm_idx;
    logic [PW-1:0] scan_idx;
    logic          cm_new;
    logic          cm_miss;

    // Head presentation and push/pop decisions; all derived from registers
    // plus the request inputs, never from disp_ready into disp_valid.
    always_comb begin
        issue_ready = (count != CW'(DEPTH));
        push        = issue_valid && issue_ready && issue_accept;
        disp_valid  = ent_valid[head] && ent_committed[head] && !ent_killed[head];
        disp_instr  = ent_instr[head];
        disp_id     = ent_id[head];
        kill_pop    = ent_valid[head] && ent_killed[head];
        disp_fire   = disp_valid && disp_ready;
        pop         = kill_pop || disp_fire;
    end

    // Find the oldest unresolved entry matching commit_id, scanning from head;
    // fall back to the entry being written this cycle, else flag an error.
    always_comb begin
        cm_hit   = 1'b0;
        cm_idx   = '0;
        scan_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head + PW'(i);
            if (!cm_hit && ent_valid[scan_idx] && (ent_id[scan_idx] == commit_id) &&
                !ent_committed[scan_idx] && !ent_killed[scan_idx]) begin
                cm_hit = 1'b1;
                cm_idx = scan_idx;
            end
        end
        cm_new  = commit_valid && !cm_hit && push && (issue_id == commit_id);
        cm_miss = commit_valid && !cm_hit && !cm_new;
    end

    // Queue storage, pointers, occupancy and the sticky commit error.
    always_ff @(posedge ck) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_instr[i] <= '0;
                ent_id[i]    <= '0;
            end
            ent_valid     <= '0;
            ent_committed <= '0;
            ent_killed    <= '0;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            commit_err    <= 1'b0;
        end else begin
            // The tail slot is always free when push is allowed, so it never
            // collides with the commit target or the popped head.
            if (push) begin
                ent_valid[tail]     <= 1'b1;
                ent_instr[tail]     <= issue_instr;
                ent_id[tail]        <= issue_id;
                ent_committed[tail] <= cm_new && !commit_kill;
                ent_killed[tail]    <= cm_new && commit_kill;
                tail                <= tail + 1'b1;
            end
            if (commit_valid && cm_hit) begin
                ent_committed[cm_idx] <= !commit_kill;
                ent_killed[cm_idx]    <= commit_kill;
            end
            if (pop) begin
                ent_valid[head] <= 1'b0;
                head            <= head + 1'b1;
            end
            if (cm_miss) begin
                commit_err <= 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef RVFPM_COMMIT_QUEUE_STATS_EN
    // Free-running statistics: dispatch handshakes and dropped killed entries.
    always_ff @(posedge ck) begin
        if (rst) begin
            disp_cnt <= '0;
            kill_cnt <= '0;
        end else begin
            if (disp_fire) disp_cnt <= disp_cnt + 32'd1;
            if (kill_pop)  kill_cnt <= kill_cnt + 32'd1;
        end
    end
`endif

endmodule
